// File: rtl/eq_pkg.sv
// Shared equalizer definitions: datapath widths, output extraction point,
// saturation limits and the band sequencer FSM encoding.
package eq_pkg;

  localparam int unsigned EQ_DATA_W = 24;
  localparam int unsigned EQ_COEF_W = 17;
  localparam int unsigned EQ_ACC_W  = 48;
  localparam int unsigned EQ_SHIFT  = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_OUT
  } eq_state_e;

  // Largest/smallest two's-complement value representable in w bits.
  function automatic longint eq_sat_hi(int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint eq_sat_lo(int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  localparam longint EQ_SAT_HI = eq_sat_hi(EQ_DATA_W);
  localparam longint EQ_SAT_LO = eq_sat_lo(EQ_DATA_W);

endpackage

// File: rtl/fir_sample_ram.sv
// Sample history ring storage: one write port, one registered read port.
// No reset so it maps onto block RAM; the owner masks stale contents.
module fir_sample_ram #(
  parameter int unsigned DEPTH = 255,
  parameter int unsigned WIDTH = 24,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
    rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/fir_band_sequencer.sv
// Multi-band FIR equalizer: one shared MAC walks N_BANDS coefficient sets
// over a single sample history ring, emitting one saturated result per band.
module fir_band_sequencer
  import eq_pkg::*;
#(
  parameter int unsigned N_TAPS  = 255,
  parameter int unsigned N_BANDS = 4,
  parameter int unsigned DATA_W  = EQ_DATA_W,
  parameter int unsigned COEF_W  = EQ_COEF_W,
  parameter int unsigned ACC_W   = EQ_ACC_W,
  parameter int unsigned SHIFT   = EQ_SHIFT,
  localparam int unsigned ADDR_W = (N_BANDS * N_TAPS > 1) ? $clog2(N_BANDS * N_TAPS) : 1,
  localparam int unsigned BAND_W = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_ready,
  output logic [ADDR_W-1:0]        o_coef_addr,
  input  logic signed [COEF_W-1:0] i_coef,
  output logic signed [DATA_W-1:0] o_band_data,
  output logic [BAND_W-1:0]        o_band_idx,
  output logic                     o_band_valid,
  output logic                     o_done,
  output logic                     o_overrun,
  input  logic                     i_ovr_clr
);

  localparam int unsigned PTR_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam logic [PTR_W-1:0]  LAST_TAP  = PTR_W'(N_TAPS - 1);
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(N_BANDS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(eq_sat_hi(DATA_W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(eq_sat_lo(DATA_W));

  eq_state_e state_q, state_d;
  logic [BAND_W-1:0] band_q, band_d;
  logic [PTR_W-1:0]  tap_q, tap_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  newest_q, newest_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              wrapped_q, wrapped_d;
  logic              drain_q, drain_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              v1_q, v1_d, first1_q, first1_d, live_q, live_d;
  logic              v2_q, v2_d, first2_q, first2_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  acc_sh;

  logic signed [DATA_W-1:0] band_data_q, band_data_d;
  logic [BAND_W-1:0]        band_idx_q, band_idx_d;
  logic band_valid_q, band_valid_d, done_q, done_d;
  logic ready_q, ready_d, overrun_q, overrun_d;

  logic              accept;
  logic [DATA_W-1:0] ram_rdata;
  logic signed [DATA_W-1:0] x_op;

  assign accept = i_valid && ready_q;

  fir_sample_ram #(
    .DEPTH(N_TAPS),
    .WIDTH(DATA_W)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (accept),
    .i_waddr(wr_ptr_q),
    .i_wdata(i_data),
    .i_raddr(rd_ptr_q),
    .o_rdata(ram_rdata)
  );

  // Entries not yet written since reset read as zero: valid only once the
  // ring has wrapped or below the write pointer.
  assign x_op   = live_q ? ram_rdata : '0;
  assign acc_sh = acc_q >>> SHIFT;

  always_comb begin
    state_d      = state_q;
    band_d       = band_q;
    tap_d        = tap_q;
    wr_ptr_d     = wr_ptr_q;
    newest_d     = newest_q;
    rd_ptr_d     = rd_ptr_q;
    wrapped_d    = wrapped_q;
    drain_d      = drain_q;
    addr_d       = addr_q;
    band_data_d  = band_data_q;
    band_idx_d   = band_idx_q;
    band_valid_d = 1'b0;
    done_d       = 1'b0;
    ready_d      = (state_q == ST_IDLE) && !accept;

    if (i_valid && !ready_q) begin
      overrun_d = 1'b1;
    end else if (i_ovr_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_RUN;
          band_d   = '0;
          tap_d    = '0;
          addr_d   = '0;
          newest_d = wr_ptr_q;
          rd_ptr_d = wr_ptr_q;
          if (wr_ptr_q == LAST_TAP) begin
            wr_ptr_d  = '0;
            wrapped_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end
      ST_RUN: begin
        rd_ptr_d = (rd_ptr_q == '0) ? LAST_TAP : rd_ptr_q - PTR_W'(1);
        if (tap_q == LAST_TAP) begin
          state_d = ST_DRAIN;
          tap_d   = '0;
          drain_d = 1'b0;
        end else begin
          tap_d  = tap_q + PTR_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        band_valid_d = 1'b1;
        band_idx_d   = band_q;
        if (acc_sh > SAT_HI) begin
          band_data_d = SAT_HI[DATA_W-1:0];
        end else if (acc_sh < SAT_LO) begin
          band_data_d = SAT_LO[DATA_W-1:0];
        end else begin
          band_data_d = acc_sh[DATA_W-1:0];
        end
        if (band_q == LAST_BAND) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          band_d  = '0;
          addr_d  = '0;
        end else begin
          state_d  = ST_RUN;
          band_d   = band_q + BAND_W'(1);
          addr_d   = addr_q + ADDR_W'(1);
          rd_ptr_d = newest_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // MAC pipeline: operands at t+1, product at t+2, accumulate at t+3.
    v1_d     = (state_q == ST_RUN);
    first1_d = (state_q == ST_RUN) && (tap_q == '0);
    live_d   = wrapped_q || (rd_ptr_q < wr_ptr_q);
    v2_d     = v1_q;
    first2_d = first1_q;
    prod_d   = v1_q ? PROD_W'(x_op) * PROD_W'(i_coef) : prod_q;
    if (v2_q) begin
      acc_d = first2_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      band_q       <= '0;
      tap_q        <= '0;
      wr_ptr_q     <= '0;
      newest_q     <= '0;
      rd_ptr_q     <= '0;
      wrapped_q    <= 1'b0;
      drain_q      <= 1'b0;
      addr_q       <= '0;
      v1_q         <= 1'b0;
      first1_q     <= 1'b0;
      live_q       <= 1'b0;
      v2_q         <= 1'b0;
      first2_q     <= 1'b0;
      prod_q       <= '0;
      acc_q        <= '0;
      band_data_q  <= '0;
      band_idx_q   <= '0;
      band_valid_q <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      band_q       <= band_d;
      tap_q        <= tap_d;
      wr_ptr_q     <= wr_ptr_d;
      newest_q     <= newest_d;
      rd_ptr_q     <= rd_ptr_d;
      wrapped_q    <= wrapped_d;
      drain_q      <= drain_d;
      addr_q       <= addr_d;
      v1_q         <= v1_d;
      first1_q     <= first1_d;
      live_q       <= live_d;
      v2_q         <= v2_d;
      first2_q     <= first2_d;
      prod_q       <= prod_d;
      acc_q        <= acc_d;
      band_data_q  <= band_data_d;
      band_idx_q   <= band_idx_d;
      band_valid_q <= band_valid_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_coef_addr  = addr_q;
  assign o_band_data  = band_data_q;
  assign o_band_idx   = band_idx_q;
  assign o_band_valid = band_valid_q;
  assign o_done       = done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_fir_band_sequencer.sv
// Scoreboard bench for fir_band_sequencer with 8 taps and 2 bands.
module tb_fir_band_sequencer;

  localparam int NT = 8;
  localparam int NB = 2;
  localparam int LAT = NT + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0;
  logic i_ovr_clr = 1'b0;
  logic signed [23:0] i_data = '0;
  logic signed [16:0] i_coef = '0;
  logic o_ready, o_band_valid, o_done, o_overrun;
  logic [3:0] o_coef_addr;
  logic signed [23:0] o_band_data;
  logic [0:0] o_band_idx;

  logic signed [16:0] rom [0:NT*NB-1];

  typedef struct {
    int cyc;
    int idx;
    int data;
    bit done;
  } exp_t;

  exp_t   sbq[$];
  exp_t   mon_e;
  longint mhist[0:NT-1];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;

  fir_band_sequencer #(
    .N_TAPS (NT),
    .N_BANDS(NB)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_coef_addr (o_coef_addr),
    .i_coef      (i_coef),
    .o_band_data (o_band_data),
    .o_band_idx  (o_band_idx),
    .o_band_valid(o_band_valid),
    .o_done      (o_done),
    .o_overrun   (o_overrun),
    .i_ovr_clr   (i_ovr_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Coefficient ROM with one cycle of read latency.
  always @(posedge clk) i_coef <= rom[o_coef_addr];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_y(input int b);
    longint acc = 0;
    for (int k = 0; k < NT; k++) acc += longint'(rom[b*NT+k]) * mhist[k];
    acc = acc >>> 15;
    if (acc > 64'sd8388607) acc = 64'sd8388607;
    else if (acc < -64'sd8388608) acc = -64'sd8388608;
    return int'(acc);
  endfunction

  task automatic rom_impulse();
    for (int k = 0; k < NT; k++) begin
      rom[k]    = 17'(k + 1);
      rom[NT+k] = -17'sd1;
    end
  endtask

  task automatic send(input logic signed [23:0] x, input bit hand,
                      input int h0, input int h1, output int acc_cyc);
    int t = 0;
    exp_t e;
    while (!o_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    acc_cyc = cyc;
    if (t >= 300) begin
      check("ready_timeout", 0, 1);
      return;
    end
    i_valid = 1'b1;
    i_data  = x;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    i_valid = 1'b0;
    for (int k = NT - 1; k > 0; k--) mhist[k] = mhist[k-1];
    mhist[0] = longint'(x);
    for (int b = 0; b < NB; b++) begin
      e.cyc  = acc_cyc + (b + 1) * LAT;
      e.idx  = b;
      e.data = hand ? ((b == 0) ? h0 : h1) : model_y(b);
      e.done = (b == NB - 1);
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(o_ready && sbq.size() == 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, o_ready, 0);
    check({tag, "_addr"}, o_coef_addr, 0);
    check({tag, "_data"}, o_band_data, 0);
    check({tag, "_idx"}, o_band_idx, 0);
    check({tag, "_valid"}, o_band_valid, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_overrun"}, o_overrun, 0);
  endtask

  // Monitor: every band result is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_band_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_band_valid: got idx %0d data %0d expected none (cycle %0d)",
                   o_band_idx, o_band_data, cyc);
        end else begin
          mon_e = sbq.pop_front();
          check("band_cycle", cyc, mon_e.cyc);
          check("band_idx", o_band_idx, mon_e.idx);
          check("band_data", o_band_data, mon_e.data);
          check("band_done", o_done, mon_e.done);
        end
      end else if (o_done) begin
        checks++;
        errors++;
        $display("FAIL done_without_valid: got 1 expected 0 (cycle %0d)", cyc);
      end
    end
  end

  initial begin
    int a;
    int wrap_v[20] = '{100000, -250000, 8388607, -8388608, 12345, 0, -1, 4000000,
                       -4000000, 777, 65536, -65536, 2097151, -2097152, 31, -31,
                       1000000, -999999, 5, 8388000};
    for (int k = 0; k < NT; k++) mhist[k] = 0;
    rom_impulse();

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", o_ready, 1);

    // Impulse; the first sample also checks the ready/done timing.
    send(24'sh008000, 1'b1, 1, -1, a);
    while (cyc < a + 2*LAT) @(negedge clk);
    check("ready_low_at_done", o_ready, 0);
    check("done_at_22", o_done, 1);
    @(negedge clk);
    check("ready_high_at_23", o_ready, 1);
    for (int n = 1; n < NT; n++) send(24'sh0, 1'b1, n + 1, -1, a);

    // Overrun: dropped sample at cycle 5, then clear+overrun together.
    wait_idle();
    send(24'sh000100, 1'b0, 0, 0, a);
    while (cyc < a + 4) @(negedge clk);
    i_valid = 1'b1;
    i_data  = 24'sh7FFFFF;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("overrun_set", o_overrun, 1);
    while (cyc < a + 8) @(negedge clk);
    i_valid   = 1'b1;
    i_ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    i_valid   = 1'b0;
    i_ovr_clr = 1'b0;
    check("overrun_set_beats_clear", o_overrun, 1);
    wait_idle();
    i_ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    i_ovr_clr = 1'b0;
    check("overrun_cleared", o_overrun, 0);
    @(negedge clk);
    send(24'sh001000, 1'b0, 0, 0, a);

    // Saturation at both rails.
    wait_idle();
    for (int k = 0; k < NT*NB; k++) rom[k] = 17'sh0FFFF;
    for (int n = 0; n < NT - 1; n++) send(24'sh7FFFFF, 1'b0, 0, 0, a);
    send(24'sh7FFFFF, 1'b1, 8388607, 8388607, a);
    for (int n = 0; n < NT - 1; n++) send(24'sh800000, 1'b0, 0, 0, a);
    send(24'sh800000, 1'b1, -8388608, -8388608, a);

    // Reset in the middle of RUN.
    wait_idle();
    rom_impulse();
    send(24'sh004000, 1'b0, 0, 0, a);
    while (cyc < a + 6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    sbq.delete();
    for (int k = 0; k < NT; k++) mhist[k] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(24'sh008000, 1'b1, 1, -1, a);

    // Twenty samples across two ring wraps against the reference FIR.
    for (int n = 0; n < 20; n++) send(24'(wrap_v[n]), 1'b0, 0, 0, a);

    wait_idle();
    check("scoreboard_empty", sbq.size(), 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_band_sequencer.md
FIR_BAND_SEQUENCER -- requirements
Module: fir_band_sequencer

Interface
REQ-001 SHALL have parameter N_TAPS, default 255, taps per band.
REQ-002 SHALL have parameter N_BANDS, default 4, equalizer bands sharing one MAC.
REQ-003 SHALL have parameters DATA_W=24 (sample width), COEF_W=17 (coefficient width), ACC_W=48 (accumulator width), SHIFT=15 (output extraction LSB).
REQ-004 SHALL have port i_clk, input, 1, clock.
REQ-005 SHALL have port i_rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port i_valid, input, 1, new-sample strobe.
REQ-007 SHALL have port i_data, input, DATA_W signed, audio sample.
REQ-008 SHALL have port o_ready, output, 1, high only in IDLE.
REQ-009 SHALL have port o_coef_addr, output, clog2(N_BANDS*N_TAPS), coefficient ROM address.
REQ-010 SHALL have port i_coef, input, COEF_W signed, ROM data, valid exactly 1 cycle after address.
REQ-011 SHALL have port o_band_data, output, DATA_W signed, filtered band output.
REQ-012 SHALL have port o_band_idx, output, clog2(N_BANDS), band of o_band_data.
REQ-013 SHALL have port o_band_valid, output, 1, one-cycle pulse per band result.
REQ-014 SHALL have port o_done, output, 1, one-cycle pulse after last band of a sample.
REQ-015 SHALL have port o_overrun, output, 1, sticky dropped-sample flag.
REQ-016 SHALL have port i_ovr_clr, input, 1, synchronous clear of o_overrun.

Function
REQ-017 SHALL accept a sample on a rising edge where i_valid && o_ready; that edge is cycle 0.
REQ-018 SHALL write the accepted sample into an internal N_TAPS-deep history ring at wr_ptr, advancing wr_ptr modulo N_TAPS (wrap N_TAPS-1 -> 0).
REQ-019 SHALL use FSM states IDLE, RUN, DRAIN, OUT: IDLE->RUN on acceptance; RUN->DRAIN after N_TAPS issue cycles; DRAIN->OUT after 2 cycles; OUT->RUN if band < N_BANDS-1, else OUT->IDLE.
REQ-020 SHALL, in RUN for band b and tap k (0..N_TAPS-1), drive o_coef_addr = b*N_TAPS + k and read history[(newest_ptr - k) mod N_TAPS].
REQ-021 SHALL pipeline as: issue (cycle t), operand register (t+1), registered product x*h of DATA_W+COEF_W bits (t+2), signed accumulate into ACC_W bits (t+3).
REQ-022 SHALL clear the accumulator at the first tap of every band; no carry-over between bands or samples.
REQ-023 SHALL produce o_band_data = acc[SHIFT+DATA_W-1:SHIFT], saturated to +(2^23-1) / -2^23 when acc exceeds that range.
REQ-024 SHALL assert o_band_valid with o_band_idx=b in cycle (b+1)*(N_TAPS+3); o_band_data holds until the next o_band_valid.
REQ-025 SHALL assert o_done in the same cycle as o_band_valid for band N_BANDS-1; o_ready rises the following cycle.
REQ-026 SHALL drop i_valid samples arriving while o_ready=0 (history unchanged) and set o_overrun.
REQ-027 SHALL keep o_overrun set until i_ovr_clr; set wins over simultaneous clear.
REQ-028 SHALL treat history as zero-initialised; before N_TAPS samples have been accepted, missing taps contribute 0.

Reset
REQ-029 SHALL on i_rst_n low, at any time including mid-RUN, force IDLE, wr_ptr=0, history=0, accumulator=0, band=0.
REQ-030 SHALL reset outputs to o_ready=0 during reset (1 from the first cycle after release), o_coef_addr=0, o_band_data=0, o_band_idx=0, o_band_valid=0, o_done=0, o_overrun=0.

Structure
REQ-031 SHALL take widths, SHIFT, saturation limits and the FSM state encoding from shared package eq_pkg.
REQ-032 SHALL place the history ring in sub-module fir_sample_ram (1 write port, 1 registered read port, inferable as block RAM).

Verification
REQ-033 Impulse: N_TAPS=8, N_BANDS=2, band0 h[k]=k+1, band1 h[k]=-1; input 0x008000, then 7 zeros -> band0 outputs 1..8, band1 outputs -1 across successive samples.
REQ-034 Timing: single sample accepted at cycle 0, N_TAPS=8 -> o_band_valid at cycles 11 and 22, o_done at 22, o_ready high at 23.
REQ-035 Saturation: all h=0x0FFFF, all inputs 0x7FFFFF -> o_band_data=0x7FFFFF; all inputs 0x800000 -> 0x800000.
REQ-036 Overrun: i_valid pulsed at cycle 5 while busy -> sample ignored, o_overrun=1; i_ovr_clr and a second overrun in the same cycle -> o_overrun stays 1.
REQ-037 Reset mid-RUN: i_rst_n low at cycle 6 -> all outputs reset values, no o_band_valid; next sample filtered against all-zero history.
REQ-038 Wrap: 20 consecutive samples with N_TAPS=8 -> outputs match a software golden FIR bit-exactly across the ring wrap.
